// File: rtl/timer.sv
// Tenths-resolution BCD stopwatch / countdown timer with key-driven mode control
// and blinking point/LED status outputs.
//
// state | meaning
// IDLE  | stopped; display shows 00.0, the last count, or the reloaded preset
// UP    | counting up from 00.0 toward the preset P.0
// DOWN  | counting down from P.0 toward 00.0
// DONE  | target reached; count held until a key moves it on
module timer (
  input  logic       cnt_10hz,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       cnt_2hz,
  input  logic       cnt_4hz,
  input  logic       en,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  input  logic       key4,
  input  logic       key5,
  input  logic       key6,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] xiaoshu,
  output logic       point,
  output logic       led
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  logic [1:0] mode;
  logic [5:0] key_q;
  logic [5:0] key_now;
  logic [5:0] press;
  logic       pause_int;
  logic [3:0] p_tens;
  logic [3:0] p_ones;
  logic [3:0] ten_c;
  logic [3:0] one_c;
  logic       preset_zero;
  logic       active;
  logic       running;
  logic [3:0] inc_t, inc_o, inc_x;
  logic [3:0] dec_t, dec_o, dec_x;

  // key bit order: {key6, key5, key4, key2, key1, key0}
  assign key_now     = {key6, key5, key4, key2, key1, key0};
  assign press       = key_q & ~key_now;
  assign ten_c       = (ten > 4'd9) ? 4'd9 : ten;
  assign one_c       = (one > 4'd9) ? 4'd9 : one;
  assign preset_zero = (ten_c == 4'd0) && (one_c == 4'd0);
  assign active      = (mode == UP) || (mode == DOWN);
  assign running     = active && en && !pause && !pause_int;

  always_comb begin
    inc_t = tens;
    inc_o = ones;
    inc_x = xiaoshu + 4'd1;
    if (xiaoshu == 4'd9) begin
      inc_x = 4'd0;
      inc_o = ones + 4'd1;
      if (ones == 4'd9) begin
        inc_o = 4'd0;
        inc_t = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end
    end
  end

  always_comb begin
    dec_t = tens;
    dec_o = ones;
    dec_x = xiaoshu - 4'd1;
    if (xiaoshu == 4'd0) begin
      dec_x = 4'd9;
      dec_o = ones - 4'd1;
      if (ones == 4'd0) begin
        dec_o = 4'd9;
        dec_t = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
      end
    end
  end

  always_ff @(posedge cnt_10hz or posedge rst_n) begin
    if (rst_n) begin
      mode      <= IDLE;
      key_q     <= 6'b111111;
      pause_int <= 1'b0;
      p_tens    <= 4'd0;
      p_ones    <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      xiaoshu   <= 4'd0;
    end else if (en) begin
      key_q <= key_now;
      if (press[2]) begin
        mode      <= IDLE;
        pause_int <= 1'b0;
        tens      <= 4'd0;
        ones      <= 4'd0;
        xiaoshu   <= 4'd0;
      end else if (press[0]) begin
        mode      <= preset_zero ? DONE : UP;
        pause_int <= 1'b0;
        p_tens    <= ten_c;
        p_ones    <= one_c;
        tens      <= 4'd0;
        ones      <= 4'd0;
        xiaoshu   <= 4'd0;
      end else if (press[1]) begin
        mode      <= preset_zero ? DONE : DOWN;
        pause_int <= 1'b0;
        p_tens    <= ten_c;
        p_ones    <= one_c;
        tens      <= ten_c;
        ones      <= one_c;
        xiaoshu   <= 4'd0;
      end else if (press[3]) begin
        if (active) pause_int <= ~pause_int;
      end else if (press[4]) begin
        if (mode == IDLE) begin
          p_tens  <= ten_c;
          p_ones  <= one_c;
          tens    <= ten_c;
          ones    <= one_c;
          xiaoshu <= 4'd0;
        end
      end else if (press[5]) begin
        if (mode == DONE) mode <= IDLE;
      end else if (running) begin
        if (mode == UP) begin
          tens    <= inc_t;
          ones    <= inc_o;
          xiaoshu <= inc_x;
          if ({inc_t, inc_o, inc_x} == {p_tens, p_ones, 4'd0}) mode <= DONE;
        end else begin
          tens    <= dec_t;
          ones    <= dec_o;
          xiaoshu <= dec_x;
          if ({dec_t, dec_o, dec_x} == 12'h000) mode <= DONE;
        end
      end
    end
  end

  always_comb begin
    point = 1'b0;
    led   = 1'b0;
    case (mode)
      UP, DOWN: begin
        point = running ? 1'b1 : clk_1hz;
        led   = running ? 1'b0 : cnt_2hz;
      end
      DONE: begin
        point = 1'b1;
        led   = cnt_4hz;
      end
      default: begin
        point = 1'b0;
        led   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: reset, count-up, count-down, pause, boundaries, enable.
module tb_timer;
  logic       cnt_10hz;
  logic       rst_n;
  logic       clk_1hz, cnt_2hz, cnt_4hz;
  logic       en;
  logic       key0, key1, key2, key4, key5, key6;
  logic [3:0] ten, one;
  logic       pause;
  logic [3:0] tens, ones, xiaoshu;
  logic       point, led;

  int errors = 0;
  int checks = 0;
  int v1, v2;

  timer dut (
    .cnt_10hz(cnt_10hz), .rst_n(rst_n),
    .clk_1hz(clk_1hz), .cnt_2hz(cnt_2hz), .cnt_4hz(cnt_4hz),
    .en(en),
    .key0(key0), .key1(key1), .key2(key2), .key4(key4), .key5(key5), .key6(key6),
    .ten(ten), .one(one), .pause(pause),
    .tens(tens), .ones(ones), .xiaoshu(xiaoshu),
    .point(point), .led(led)
  );

  initial cnt_10hz = 1'b0;
  always #5 cnt_10hz = ~cnt_10hz;

  function automatic int disp();
    return (int'(tens) << 8) | (int'(ones) << 4) | int'(xiaoshu);
  endfunction

  function automatic int to_tenths(input int d);
    return ((d >> 8) & 15) * 100 + ((d >> 4) & 15) * 10 + (d & 15);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cnt_10hz);
    #1;
  endtask

  task automatic press(input int idx);
    case (idx)
      0: key0 = 1'b0;
      1: key1 = 1'b0;
      2: key2 = 1'b0;
      4: key4 = 1'b0;
      5: key5 = 1'b0;
      default: key6 = 1'b0;
    endcase
    step(1);
    {key0, key1, key2, key4, key5, key6} = 6'b111111;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b1; pause = 1'b0;
    clk_1hz = 1'b0; cnt_2hz = 1'b0; cnt_4hz = 1'b0;
    {key0, key1, key2, key4, key5, key6} = 6'b111111;
    ten = 4'd0; one = 4'd0;
    step(2);
    chk("rst_disp", disp(), 'h000);
    chk("rst_mode", int'(dut.mode), 0);
    chk("rst_point", int'(point), 0);
    chk("rst_led", int'(led), 0);
    rst_n = 1'b0;
    step(1);

    // count-up to 15.0
    ten = 4'd1; one = 4'd5;
    press(0);
    chk("up_start", disp(), 'h000);
    chk("up_mode", int'(dut.mode), 1);
    step(1);
    chk("up_first", disp(), 'h001);
    chk("up_point_run", int'(point), 1);
    chk("up_led_run", int'(led), 0);
    step(9);
    chk("up_10", disp(), 'h010);
    step(140);
    chk("up_end", disp(), 'h150);
    chk("up_done", int'(dut.mode), 3);
    step(3);
    chk("up_hold", disp(), 'h150);
    chk("done_point", int'(point), 1);
    cnt_4hz = 1'b1; #1;
    chk("done_led_hi", int'(led), 1);
    cnt_4hz = 1'b0; #1;
    chk("done_led_lo", int'(led), 0);
    step(1);

    // count-down from 15.0
    press(1);
    chk("dn_start", disp(), 'h150);
    chk("dn_mode", int'(dut.mode), 2);
    step(1);
    chk("dn_first", disp(), 'h149);
    step(9);
    chk("dn_10", disp(), 'h140);
    step(140);
    chk("dn_end", disp(), 'h000);
    chk("dn_done", int'(dut.mode), 3);
    press(6);
    chk("ack_mode", int'(dut.mode), 0);
    chk("ack_disp", disp(), 'h000);

    // external pause, then internal pause via key4
    ten = 4'd9; one = 4'd9;
    press(0);
    step(5);
    chk("ps_pre", disp(), 'h005);
    pause = 1'b1;
    step(1);
    chk("ps_frz1", disp(), 'h005);
    clk_1hz = 1'b1; cnt_2hz = 1'b0; #1;
    chk("ps_point_hi", int'(point), 1);
    chk("ps_led_lo", int'(led), 0);
    clk_1hz = 1'b0; cnt_2hz = 1'b1; #1;
    chk("ps_point_lo", int'(point), 0);
    chk("ps_led_hi", int'(led), 1);
    step(20);
    chk("ps_frz20", disp(), 'h005);
    pause = 1'b0;
    step(1);
    chk("ps_resume", disp(), 'h006);
    step(4);
    chk("ps_resume4", disp(), 'h010);
    press(4);
    step(2);
    v1 = to_tenths(disp());
    step(20);
    chk("k4_frz", to_tenths(disp()), v1);
    chk("k4_point", int'(point), int'(clk_1hz));
    chk("k4_led", int'(led), int'(cnt_2hz));
    press(4);
    step(2);
    v2 = to_tenths(disp());
    step(5);
    chk("k4_resume", to_tenths(disp()) - v2, 5);
    chk("k4_run_point", int'(point), 1);

    // boundaries
    press(2);
    chk("clr_mode", int'(dut.mode), 0);
    chk("clr_disp", disp(), 'h000);
    chk("idle_point", int'(point), 0);
    ten = 4'd12; one = 4'd3;
    press(5);
    chk("clamp_reload", disp(), 'h930);
    chk("reload_mode", int'(dut.mode), 0);
    ten = 4'd0; one = 4'd0;
    press(1);
    chk("p0_dn_mode", int'(dut.mode), 3);
    chk("p0_dn_disp", disp(), 'h000);
    press(0);
    chk("p0_up_mode", int'(dut.mode), 3);
    step(2);
    chk("p0_up_disp", disp(), 'h000);
    ten = 4'd1; one = 4'd5;
    press(1);
    key0 = 1'b0; key2 = 1'b0;
    step(1);
    key0 = 1'b1; key2 = 1'b1;
    chk("prio_mode", int'(dut.mode), 0);
    chk("prio_disp", disp(), 'h000);
    step(2);
    chk("prio_hold", disp(), 'h000);

    // enable gating during DOWN
    press(1);
    step(3);
    chk("en_pre", disp(), 'h147);
    en = 1'b0;
    step(5);
    chk("en_hold", disp(), 'h147);
    key0 = 1'b0;
    step(2);
    key0 = 1'b1;
    step(2);
    en = 1'b1;
    step(1);
    chk("en_resume", disp(), 'h146);
    chk("en_mode", int'(dut.mode), 2);

    // asynchronous reset mid-count
    step(3);
    chk("ar_pre", disp(), 'h143);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ar_disp", disp(), 'h000);
    chk("ar_mode", int'(dut.mode), 0);
    chk("ar_point", int'(point), 0);
    chk("ar_led", int'(led), 0);
    step(1);
    rst_n = 1'b0;
    step(3);
    chk("ar_after", disp(), 'h000);
    chk("ar_after_mode", int'(dut.mode), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
